traffic_phase_ctrl: RTL and testbench

Parametrised, clocked successor to the fixed six-state intersection sequencer. It serves `NUM_APPROACHES` approaches one at a time with timed green, yellow and all-red clearance intervals. Green time adapts to per-approach vehicle counts, idle approaches are skipped, and a preemption request forces service to one approach. It sits between the vehicle-detector counters and the lamp drivers.

---
 rtl/traffic_phase_ctrl.sv | 172 +++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Adaptive, preemptable intersection sequencer: serves one approach at a time
// through GREEN / YELLOW / ALL_RED intervals timed in ticks.
module traffic_phase_ctrl #(
  parameter int unsigned NUM_APPROACHES = 4,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned TIMER_W        = 8,
  parameter int unsigned MIN_GREEN      = 10,
  parameter int unsigned MAX_GREEN      = 40,
  parameter int unsigned YELLOW_TIME    = 4,
  parameter int unsigned ALL_RED_TIME   = 2,
  parameter int unsigned EXT_THRESHOLD  = 3,
  localparam int unsigned PH_W          = $clog2(NUM_APPROACHES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [NUM_APPROACHES*CNT_W-1:0] veh_count,
  input  logic                          preempt_req,
  input  logic [PH_W-1:0]               preempt_id,
  output logic [NUM_APPROACHES*3-1:0]   lights,
  output logic [PH_W-1:0]               active_phase,
  output logic                          phase_start
);

  localparam int unsigned NSLOT = 1 << PH_W;
  localparam int unsigned SUM_W = PH_W + 1;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [PH_W-1:0]            cur_q, cur_d;
  logic [TIMER_W-1:0]         timer_q, timer_d;
  logic [TIMER_W:0]           elapsed;
  logic [CNT_W-1:0]           counts [NSLOT];
  logic [CNT_W-1:0]           cur_count;
  logic                       preempt_valid;
  logic                       hold;
  logic                       abort;
  logic                       rr_found;
  logic [PH_W-1:0]            rr_pick;
  logic [PH_W-1:0]            seq_next;
  logic [PH_W-1:0]            next_phase;
  logic [NUM_APPROACHES*3-1:0] lights_d;
  logic                       phase_start_d;

  // Unpack detector counts; slots beyond NUM_APPROACHES read as idle.
  always_comb begin
    for (int unsigned i = 0; i < NSLOT; i++) begin
      counts[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_APPROACHES; i++) begin
      counts[i] = veh_count[i*CNT_W +: CNT_W];
    end
  end

  assign cur_count     = counts[cur_q];
  assign elapsed       = {1'b0, timer_q} + SUM_W'(0) + (TIMER_W+1)'(1);
  assign preempt_valid = preempt_req &&
                         ({1'b0, preempt_id} < SUM_W'(NUM_APPROACHES));
  assign hold          = preempt_req && (preempt_id == cur_q);
  assign abort         = preempt_valid && (preempt_id != cur_q);

  // Round-robin search starting after cur, cur itself examined last.
  always_comb begin
    logic [SUM_W-1:0] sum;
    rr_found = 1'b0;
    rr_pick  = cur_q;
    seq_next = cur_q;
    sum      = '0;
    for (int unsigned k = 1; k <= NUM_APPROACHES; k++) begin
      sum = {1'b0, cur_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_APPROACHES)) begin
        sum = sum - SUM_W'(NUM_APPROACHES);
      end
      if (k == 1) begin
        seq_next = sum[PH_W-1:0];
      end
      if (!rr_found && (counts[sum[PH_W-1:0]] != '0)) begin
        rr_found = 1'b1;
        rr_pick  = sum[PH_W-1:0];
      end
    end
  end

  always_comb begin
    next_phase = seq_next;
    if (preempt_valid) begin
      next_phase = preempt_id;
    end else if (rr_found) begin
      next_phase = rr_pick;
    end
  end

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ALL_RED;
      cur_q        <= PH_W'(NUM_APPROACHES - 1);
      timer_q      <= '0;
      lights       <= {NUM_APPROACHES{3'b100}};
      active_phase <= PH_W'(NUM_APPROACHES - 1);
      phase_start  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      timer_q      <= timer_d;
      lights       <= lights_d;
      active_phase <= cur_d;
      phase_start  <= phase_start_d;
    end
  end

  // Next-state and interval timer.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    if (tick && (timer_q != '1)) begin
      timer_d = timer_q + TIMER_W'(1);
    end
    case (state_q)
      S_ALL_RED: begin
        if (tick && (32'(elapsed) == ALL_RED_TIME)) begin
          state_d = S_GREEN;
          cur_d   = next_phase;
        end
      end
      S_GREEN: begin
        if (hold) begin
          state_d = S_GREEN;
        end else if (abort) begin
          state_d = S_YELLOW;
        end else if (tick && ((32'(elapsed) >= MAX_GREEN) ||
                              ((32'(elapsed) >= MIN_GREEN) &&
                               (32'(cur_count) < EXT_THRESHOLD)))) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (tick && (32'(elapsed) == YELLOW_TIME)) begin
          state_d = S_ALL_RED;
        end
      end
      default: begin
        state_d = S_ALL_RED;
      end
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // Lamp decode and green-entry pulse.
  always_comb begin
    lights_d      = {NUM_APPROACHES{3'b100}};
    phase_start_d = (state_d == S_GREEN) && (state_q != S_GREEN);
    for (int unsigned i = 0; i < NUM_APPROACHES; i++) begin
      if (cur_d == PH_W'(i)) begin
        if (state_d == S_GREEN) begin
          lights_d[3*i +: 3] = 3'b001;
        end else if (state_d == S_YELLOW) begin
          lights_d[3*i +: 3] = 3'b010;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios on a 4-approach instance plus
// a 5-approach instance that only ever sees an out-of-range preemption target.
module tb_traffic_phase_ctrl;

  localparam int unsigned NA = 4, NB = 5, CW = 5, TW = 8;
  localparam int unsigned MING = 3, MAXG = 6, YT = 2, ART = 1, EXT = 3;
  localparam int AR = 0, GR = 1, YE = 2;

  logic clk = 1'b0;
  logic rst, tick, preq_a, preq_b;
  logic [NA*CW-1:0] veh_a;
  logic [NB*CW-1:0] veh_b;
  logic [1:0] pid_a;
  logic [2:0] pid_b;
  logic [NA*3-1:0] lights_a;
  logic [NB*3-1:0] lights_b;
  logic [1:0] ap_a;
  logic [2:0] ap_b;
  logic ps_a, ps_b;

  int n_vec = 0;
  int n_bad = 0;

  int m_state [2];
  int m_cur   [2];
  int m_timer [2];
  bit m_ps    [2];
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.NUM_APPROACHES(NA), .CNT_W(CW), .TIMER_W(TW), .MIN_GREEN(MING),
    .MAX_GREEN(MAXG), .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .EXT_THRESHOLD(EXT)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .veh_count(veh_a), .preempt_req(preq_a),
    .preempt_id(pid_a), .lights(lights_a), .active_phase(ap_a), .phase_start(ps_a));

  traffic_phase_ctrl #(.NUM_APPROACHES(NB), .CNT_W(CW), .TIMER_W(TW), .MIN_GREEN(MING),
    .MAX_GREEN(MAXG), .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .EXT_THRESHOLD(EXT)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .veh_count(veh_b), .preempt_req(preq_b),
    .preempt_id(pid_b), .lights(lights_b), .active_phase(ap_b), .phase_start(ps_b));

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int k, input int i);
    if (k == 0) return int'(veh_a[i*CW +: CW]);
    return int'(veh_b[i*CW +: CW]);
  endfunction

  function automatic logic [47:0] exp_lights(input int k);
    logic [47:0] v;
    int n;
    n = (k == 0) ? NA : NB;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (i == m_cur[k] && m_state[k] == GR) v[3*i +: 3] = 3'b001;
      else if (i == m_cur[k] && m_state[k] == YE) v[3*i +: 3] = 3'b010;
      else v[3*i +: 3] = 3'b100;
    end
    return v;
  endfunction

  // Behavioural phase model, advanced one clock edge at a time.
  task automatic model_step(input int k);
    int n, pid, t, ns, nc, old;
    bit preq, valid, found;
    n    = (k == 0) ? NA : NB;
    pid  = (k == 0) ? int'(pid_a) : int'(pid_b);
    preq = (k == 0) ? preq_a : preq_b;
    valid = preq && (pid < n);
    old  = m_state[k];
    ns   = old;
    nc   = m_cur[k];
    t    = m_timer[k] + 1;
    if (rst) begin
      m_state[k] = AR; m_cur[k] = n - 1; m_timer[k] = 0; m_ps[k] = 1'b0;
      return;
    end
    if (old == AR) begin
      if (tick && t == ART) begin
        ns = GR;
        if (valid) nc = pid;
        else begin
          found = 1'b0;
          nc = (m_cur[k] + 1) % n;
          for (int j = 1; j <= n; j++) begin
            if (!found && cnt_of(k, (m_cur[k] + j) % n) != 0) begin
              found = 1'b1;
              nc = (m_cur[k] + j) % n;
            end
          end
        end
      end
    end else if (old == GR) begin
      if (preq && pid == m_cur[k]) ns = GR;
      else if (valid) ns = YE;
      else if (tick && (t >= MAXG || (t >= MING && cnt_of(k, m_cur[k]) < EXT))) ns = YE;
    end else begin
      if (tick && t == YT) ns = AR;
    end
    if (ns != old) m_timer[k] = 0;
    else if (tick && m_timer[k] < 255) m_timer[k] = m_timer[k] + 1;
    m_ps[k]    = (ns == GR) && (old != GR);
    m_state[k] = ns;
    m_cur[k]   = nc;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("lights_a", 48'(lights_a), exp_lights(0));
      check("phase_a", 48'(ap_a), 48'(m_cur[0]));
      check("start_a", 48'(ps_a), 48'(m_ps[0]));
      check("lights_b", 48'(lights_b), exp_lights(1));
      check("phase_b", 48'(ap_b), 48'(m_cur[1]));
      check("start_b", 48'(ps_b), 48'(m_ps[1]));
    end
  end

  // Counts consecutive cycles showing pat, starting at the current negedge.
  task automatic measure(input logic [11:0] pat, input int want, input string name);
    int n;
    n = 0;
    while (lights_a === pat && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, 48'(n), 48'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; tick = 1'b1; preq_a = 1'b0; pid_a = 2'd0;
    preq_b = 1'b1; pid_b = 3'd5;
    veh_a = '0;
    veh_b = (25'd7 << 15) | (25'd2 << 5);
    @(negedge clk);
    @(negedge clk);
    check("rst_lights", 48'(lights_a), 48'h924);
    check("rst_phase", 48'(ap_a), 48'd3);
    check("rst_start", 48'(ps_a), 48'd0);
    check("rst_phase_b", 48'(ap_b), 48'd4);

    rst = 1'b0;
    veh_a = (20'd5 << 10) | 20'd1;
    @(negedge clk);
    check("first_green", 48'(lights_a), 48'h921);
    check("first_start", 48'(ps_a), 48'd1);
    check("b_skip_ignores_id5", 48'(ap_b), 48'd1);
    measure(12'h921, 3, "min_green_len");
    measure(12'h922, 2, "yellow_len");
    measure(12'h924, 1, "all_red_len");
    check("skip_to_2", 48'(lights_a), 48'h864);
    check("skip_start", 48'(ps_a), 48'd1);
    measure(12'h864, 6, "max_green_len_2");
    veh_a = 20'd9;
    measure(12'h8A4, 2, "yellow2_len");
    measure(12'h924, 1, "all_red2_len");
    measure(12'h921, 6, "max_green_len_0");
    measure(12'h922, 2, "yellow3_len");
    measure(12'h924, 1, "all_red3_len");

    check("regreen_0", 48'(lights_a), 48'h921);
    n = 0;
    while (lights_a === 12'h921 && n < 200) begin
      n++;
      tick = (n >= 3 && n <= 6) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    tick = 1'b1;
    check("tick_gap_green_len", 48'(n), 48'd10);
    measure(12'h922, 2, "yellow4_len");
    measure(12'h924, 1, "all_red4_len");

    check("pre_green_0", 48'(lights_a), 48'h921);
    preq_a = 1'b1; pid_a = 2'd3;
    @(negedge clk);
    check("abort_yellow", 48'(lights_a), 48'h922);
    measure(12'h922, 2, "abort_yellow_len");
    measure(12'h924, 1, "abort_all_red_len");
    check("preempt_green_3", 48'(lights_a), 48'h324);
    check("preempt_start", 48'(ps_a), 48'd1);
    for (int i = 1; i < 20; i++) @(negedge clk);
    check("held_green_3", 48'(lights_a), 48'h324);
    preq_a = 1'b0; veh_a = '0;
    @(negedge clk);
    check("release_yellow", 48'(lights_a), 48'h524);

    rst = 1'b1;
    @(negedge clk);
    check("midrst_lights", 48'(lights_a), 48'h924);
    check("midrst_phase", 48'(ap_a), 48'd3);
    check("midrst_start", 48'(ps_a), 48'd0);
    rst = 1'b0;
    pid_b = 3'd7;
    @(negedge clk);
    check("post_rst_green", 48'(lights_a), 48'h921);
    measure(12'h921, 3, "post_rst_min_green");
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
